text_render_ctrl: RTL and testbench



---
 rtl/txt_pkg.sv | 48 ++++
 rtl/sync_delay.sv | 24 ++
 rtl/text_render_ctrl.sv | 107 ++++++++++
 tb/tb_text_render_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/txt_pkg.sv
// txt_pkg: shared geometry, text-word field layout and pipeline-stage records
// for the text-mode renderer.
package txt_pkg;
    localparam int COLS_DEF  = 80;
    localparam int ROWS_DEF  = 30;
    localparam int CELL_W    = 8;
    localparam int CELL_H    = 16;
    localparam int PIPE_LAT  = 4;
    localparam int GLYPH_LSB = 0;
    localparam int GLYPH_W   = 7;
    localparam int INV_BIT   = 7;
    localparam int FG_LSB    = 8;
    localparam int BG_LSB    = 12;

    typedef struct packed {
        logic       v;
        logic       oob;
        logic       hit;
        logic [2:0] px;
        logic [3:0] py;
    } s1_t;

    typedef struct packed {
        logic       v;
        logic       oob;
        logic       hit;
        logic [2:0] px;
        logic       inv;
        logic [3:0] fg;
        logic [3:0] bg;
    } s2_t;

    typedef struct packed {
        logic       v;
        logic       pix;
        logic [3:0] fg;
        logic [3:0] bg;
    } s3_t;

    // Constant multiply as a sum of shifted copies of row, one per set bit of k.
    function automatic logic [11:0] mul_const(input logic [4:0] row, input logic [11:0] k);
        logic [11:0] acc;
        acc = '0;
        for (int i = 0; i < 12; i++)
            if (k[i]) acc = acc + (12'(row) << i);
        return acc;
    endfunction
endpackage

// File: rtl/sync_delay.sv
// sync_delay: fixed-depth register delay line, cleared by the asynchronous reset.
module sync_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/text_render_ctrl.sv
// text_render_ctrl: four-stage text-mode pixel pipeline: cell address, font
// fetch, pixel select with inverse/cursor, then registered colour.
module text_render_ctrl
    import txt_pkg::*;
#(
    parameter int COLS         = COLS_DEF,
    parameter int ROWS         = ROWS_DEF,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [11:0] txt_addr,
    input  logic [15:0] txt_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic [3:0]  color
);
    localparam logic [7:0] COLS_L     = 8'(COLS);
    localparam logic [5:0] ROWS_L     = 6'(ROWS);
    localparam logic [4:0] BLINK_LAST = 5'(BLINK_FRAMES - 1);

    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic        de_prev_q, vs_prev_q, blink_q, blink_d;
    logic [4:0]  blink_cnt_q, blink_cnt_d;
    logic [11:0] txt_addr_q, txt_addr_d;
    logic [3:0]  color_q, color_d;
    logic [2:0]  tim;
    logic        de_fall, vs_rise, wrap;
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    s3_t         s3_q, s3_d;

    function automatic logic oob(input logic [6:0] col, input logic [4:0] row);
        return {1'b0, col} >= COLS_L || {1'b0, row} >= ROWS_L;
    endfunction

    always_comb begin
        de_fall     = de_prev_q & ~de_in;
        vs_rise     = vs_in & ~vs_prev_q;
        wrap        = vs_rise && blink_cnt_q == BLINK_LAST;
        px_d        = de_in ? px_q + 10'd1 : '0;
        py_d        = vs_rise ? '0 : de_fall ? py_q + 9'd1 : py_q;
        blink_cnt_d = wrap ? '0 : vs_rise ? blink_cnt_q + 5'd1 : blink_cnt_q;
        blink_d     = blink_q ^ wrap;
        // Built from next-state px/py so the registered address is presented in the pixel's own S1 cycle.
        txt_addr_d  = oob(px_d[9:3], py_d[8:4]) ? '0 : mul_const(py_d[8:4], 12'(COLS)) + 12'(px_d[9:3]);
        s1_d = '{v: de_in, oob: oob(px_q[9:3], py_q[8:4]),
                 hit: px_q[9:3] == cursor_col && py_q[8:4] == cursor_row,
                 px: px_q[2:0], py: py_q[3:0]};
        s2_d = '{v: s1_q.v, oob: s1_q.oob, hit: s1_q.hit, px: s1_q.px, inv: txt_data[INV_BIT],
                 fg: txt_data[FG_LSB +: 4], bg: txt_data[BG_LSB +: 4]};
        s3_d = '{v: s2_q.v & ~s2_q.oob,
                 pix: font_data[~s2_q.px] ^ s2_q.inv ^ (s2_q.hit & blink_q & cursor_en),
                 fg: s2_q.fg, bg: s2_q.bg};
        color_d = s3_q.v ? (s3_q.pix ? s3_q.fg : s3_q.bg) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q        <= '0;
            py_q        <= '0;
            de_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            txt_addr_q  <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            color_q     <= '0;
        end else begin
            px_q        <= px_d;
            py_q        <= py_d;
            de_prev_q   <= de_in;
            vs_prev_q   <= vs_in;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            txt_addr_q  <= txt_addr_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            color_q     <= color_d;
        end
    end

    sync_delay #(.DEPTH(PIPE_LAT), .WIDTH(3)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({de_in, hs_in, vs_in}),
        .dout (tim)
    );

    assign {de_out, hs_out, vs_out} = tim;
    assign txt_addr  = txt_addr_q;
    assign font_addr = s1_q.v ? {txt_data[GLYPH_LSB +: GLYPH_W], s1_q.py} : '0;
    assign color     = color_q;
endmodule

// File: tb/tb_text_render_ctrl.sv
// tb_text_render_ctrl: randomized stimulus, reference model pushes expected
// addresses and pixels into queues, a negedge monitor pops and compares.
module tb_text_render_ctrl;
    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int BLINK = 32;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        de_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, cursor_en = 1'b0;
    logic [6:0]  cursor_col = '0;
    logic [4:0]  cursor_row = '0;
    logic [15:0] txt_data = '0;
    logic [7:0]  font_data = '0;
    logic [11:0] txt_addr;
    logic [10:0] font_addr;
    logic        de_out, hs_out, vs_out;
    logic [3:0]  color;

    logic [15:0] tram [4096];
    logic [7:0]  fram [2048];

    typedef struct {int due; logic [15:0] val;} item_t;
    item_t q_addr[$], q_font[$], q_pix[$];

    int   cyc = 0, n_cmp = 0, n_err = 0;
    int   px = 0, py = 0, rises = 0;
    logic de_prev = 1'b0, vs_prev = 1'b0, in_rst = 1'b0;

    text_render_ctrl dut (
        .clk(clk), .rst_n(rst_n), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .txt_addr(txt_addr), .txt_data(txt_data), .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .color(color)
    );

    always #5 clk = ~clk;

    // External text RAM and font ROM, each a registered read.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        txt_data  <= tram[txt_addr];
        font_data <= fram[font_addr];
    end

    task automatic check(input string nm, input item_t it, input logic [15:0] act);
        n_cmp++;
        if (it.due != cyc || act !== it.val) begin
            n_err++;
            $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", nm, cyc, it.due, act, it.val);
        end
    endtask

    always @(negedge clk) begin
        while (q_addr.size() > 0 && q_addr[0].due <= cyc) check("txt_addr", q_addr.pop_front(), 16'(txt_addr));
        while (q_font.size() > 0 && q_font[0].due <= cyc) check("font_addr", q_font.pop_front(), 16'(font_addr));
        while (q_pix.size() > 0 && q_pix[0].due <= cyc)
            check("pixel{de,hs,vs,color}", q_pix.pop_front(), {9'h0, de_out, hs_out, vs_out, color});
    end

    // Applies one cycle of timing and pushes what the outputs must show for it.
    task automatic drive(input logic de, input logic hs, input logic vs);
        int col, row, a;
        logic inr, b;
        logic [15:0] w;
        logic [10:0] fa;
        logic [3:0] c;
        de_in = de; hs_in = hs; vs_in = vs;
        if (in_rst) begin
            q_addr.push_back('{cyc, 16'h0});
            q_font.push_back('{cyc + 1, 16'h0});
            q_pix.push_back('{cyc + 4, 16'h0});
        end else begin
            col = px / 8;
            row = py / 16;
            inr = col < COLS && row < ROWS;
            a   = inr ? row * COLS + col : 0;
            w   = tram[a];
            fa  = {w[6:0], 4'(py % 16)};
            b   = fram[fa][7 - px % 8] ^ w[7] ^
                  (cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && (rises / BLINK) % 2 == 1);
            c   = (de && inr) ? (b ? w[11:8] : w[15:12]) : 4'h0;
            q_addr.push_back('{cyc, 16'(a)});
            q_font.push_back('{cyc + 1, 16'(de ? fa : 11'h0)});
            q_pix.push_back('{cyc + 4, {9'h0, de, hs, vs, c}});
            if (vs && !vs_prev) begin
                rises++;
                py = 0;
            end else if (de_prev && !de) py++;
            px = de ? px + 1 : 0;
            de_prev = de;
            vs_prev = vs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic de);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({de_out, hs_out, vs_out, color, txt_addr, font_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=0", {de_out, hs_out, vs_out, color, txt_addr, font_addr});
        end
        q_addr.delete(); q_font.delete(); q_pix.delete();
        px = 0; py = 0; rises = 0; de_prev = 1'b0; vs_prev = 1'b0;
        in_rst = 1'b1;
        repeat (3) drive(de, 1'b0, 1'b0);
        rst_n  = 1'b1;
        in_rst = 1'b0;
    endtask

    task automatic line(input int len, input int blank, input logic vs_at_fall);
        repeat (len) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < blank; i++) drive(1'b0, i >= 1 && i < 3, vs_at_fall && i < 2);
    endtask

    task automatic vpulse();
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        foreach (tram[i]) tram[i] = 16'($urandom);
        foreach (fram[i]) fram[i] = 8'($urandom);
        tram[0]       = 16'hF041;
        fram[11'h410] = 8'b0001_1000;
        tram[1]       = 16'h5AD5;
        for (int r = 0; r < 16; r++) fram[{7'h55, 4'(r)}] = 8'hFF;
        @(posedge clk);
        #1;
        do_reset(1'b0);
        line(24, 6, 1'b0);
        vpulse();
        for (int l = 0; l < 40; l++) line($urandom_range(24, 48), $urandom_range(3, 8), 1'b0);
        // Cursor blink across 70 frames; only every 8th frame is tall enough to reach the cursor row.
        cursor_col = 7'd2; cursor_row = 5'd1; cursor_en = 1'b1;
        for (int f = 0; f < 70; f++) begin
            vpulse();
            repeat ((f % 8 == 0) ? 18 : 1) line(24, 5, 1'b0);
        end
        cursor_en = 1'b0;
        repeat (20) line(20, 4, 1'b0);
        line(20, 6, 1'b1);
        line(20, 4, 1'b0);
        repeat (3) line(20, 4, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        repeat (12) drive(1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        repeat (12) drive(1'b1, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0);
        vpulse();
        line(660, 6, 1'b0);
        repeat (490) line(8, 2, 1'b0);
        line(24, 4, 1'b0);
        repeat (8) drive(1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        n_cmp++;
        if (q_addr.size() + q_font.size() + q_pix.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d want=0 pending", q_addr.size() + q_font.size() + q_pix.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
